// File: rtl/nfc_rx_pkg.sv
// Shared types and helpers for the NFC receive decoder.
//   rx_state_e     : decoder FSM states
//   BITS_PER_BYTE  : data bits plus odd-parity bit per received byte
//   odd_parity_ok  : checks odd parity over a received 9-bit word
package nfc_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSofH1,
        StSofH2,
        StH1,
        StH2
    } rx_state_e;

    localparam int unsigned BITS_PER_BYTE = 9;

    // True when the 8 data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [BITS_PER_BYTE-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/nfc_rx_sampler.sv
// Input conditioning and half-bit timing for the NFC receive decoder.
//   clk, rst    : emulation clock, asynchronous active-high reset
//   rx_in       : raw demodulated line (idle 0)
//   rs          : conditioned line (2-cycle latency, 3 with the glitch filter)
//   rs_edge     : rs differs from its value in the previous cycle
//   sample_stb  : mid-half-bit sampling strobe
// Build option: NFC_RX_GLITCH_FILTER_EN adds a 3-sample majority filter after the
// synchronizer, rejecting single-cycle pulses.
module nfc_rx_sampler
    import nfc_rx_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rs,
    output logic rs_edge,
    output logic sample_stb
);

    localparam logic [CNT_W-1:0] HalfLoad = CNT_W'(HALF_BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FullLoad = CNT_W'(HALF_BIT_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             rs_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef NFC_RX_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    // Majority of the three most recent synchronized samples.
    assign rs = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rs = sync2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_prev_q <= 1'b0;
        end else begin
            rs_prev_q <= rs;
        end
    end

    assign rs_edge    = rs ^ rs_prev_q;
    assign sample_stb = (cnt_q == '0);

    // Every edge recentres the next sample half a half-bit later. In idle this only
    // matters for the SOF rising edge; other reloads are harmless since strobes are
    // ignored there.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (rs_edge) begin
            cnt_d = HalfLoad;
        end else if (sample_stb) begin
            cnt_d = FullLoad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nfc_rx_decoder.sv
// Manchester frame decoder for the NFC emulation link (one per link direction).
// Recovers SOF, LSB-first data bytes with odd parity, and EOF from the demodulated line
// and hands bytes out over a valid/ready interface.
//   clk, rst      : emulation clock, asynchronous active-high reset
//   rx_in         : demodulated line, idle 0
//   data_out      : received byte
//   data_valid    : data_out holds an unconsumed byte
//   data_ready    : consumer accepts the byte when data_valid & data_ready
//   frame_active  : SOF detected, frame not yet ended or aborted
//   frame_end     : one-cycle pulse on a valid EOF
//   parity_err    : sticky per frame, cleared at the next SOF
//   code_err      : one-cycle pulse on an illegal symbol or truncated byte
//   overflow      : sticky, a byte was dropped; cleared only by rst
// Build option: NFC_RX_GLITCH_FILTER_EN (see nfc_rx_sampler).
module nfc_rx_decoder
    import nfc_rx_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_active,
    output logic       frame_end,
    output logic       parity_err,
    output logic       code_err,
    output logic       overflow
);

    localparam logic [3:0] LastBit = 4'(BITS_PER_BYTE - 1);

    logic rs, rs_edge, sample_stb, sample_bit;

    rx_state_e  state_q, state_d;
    logic       h1_q, h1_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [8:0] byte_word;
    logic       byte_done;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       parity_err_q, parity_err_d;
    logic       overflow_q, overflow_d;
    logic       frame_end_q, frame_end_d;
    logic       code_err_q, code_err_d;

    nfc_rx_sampler #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rs        (rs),
        .rs_edge   (rs_edge),
        .sample_stb(sample_stb)
    );

    // Value of rs just before any edge in this cycle: a strobe coinciding with an edge
    // belongs to the half that is ending.
    assign sample_bit = rs ^ rs_edge;

    // For a legal data symbol the decoded bit equals its first half.
    assign byte_word = {h1_q, shift_q};

    always_comb begin
        state_d      = state_q;
        h1_d         = h1_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        frame_end_d  = 1'b0;
        code_err_d   = 1'b0;
        byte_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rs_edge && rs) begin
                    state_d      = StSofH1;
                    bit_cnt_d    = '0;
                    parity_err_d = 1'b0;
                end
            end
            StSofH1: begin
                // A low sample here means a glitch, not a frame: drop it silently.
                if (sample_stb) begin
                    state_d = sample_bit ? StSofH2 : StIdle;
                end
            end
            StSofH2: begin
                if (sample_stb) begin
                    if (!sample_bit) begin
                        state_d = StH1;
                    end else begin
                        code_err_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StH1: begin
                if (sample_stb) begin
                    h1_d    = sample_bit;
                    state_d = StH2;
                end
            end
            StH2: begin
                if (sample_stb) begin
                    if (h1_q != sample_bit) begin
                        shift_d = byte_word[8:1];
                        state_d = StH1;
                        if (bit_cnt_q == LastBit) begin
                            byte_done = 1'b1;
                            bit_cnt_d = '0;
                            if (!odd_parity_ok(byte_word)) begin
                                parity_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (!h1_q) begin
                        // EOF is only clean on a byte boundary.
                        state_d = StIdle;
                        if (bit_cnt_q == '0) begin
                            frame_end_d = 1'b1;
                        end else begin
                            code_err_d = 1'b1;
                        end
                    end else begin
                        state_d    = StIdle;
                        code_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Single-entry output buffer; a handshake in the same cycle frees room for a new byte.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || data_ready) begin
                data_d  = byte_word[7:0];
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            h1_q         <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_end_q  <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            h1_q         <= h1_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
            frame_end_q  <= frame_end_d;
            code_err_q   <= code_err_d;
        end
    end

    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign frame_active = (state_q != StIdle);
    assign frame_end    = frame_end_q;
    assign parity_err   = parity_err_q;
    assign code_err     = code_err_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_nfc_rx_decoder.sv
// Directed bench for nfc_rx_decoder at HALF_BIT_CYCLES=8.
module tb_nfc_rx_decoder;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_active;
    logic       frame_end;
    logic       parity_err;
    logic       code_err;
    logic       overflow;

    always #5 clk = ~clk;

    nfc_rx_decoder #(
        .HALF_BIT_CYCLES(H),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_active(frame_active),
        .frame_end   (frame_end),
        .parity_err  (parity_err),
        .code_err    (code_err),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event counters sampled on the falling edge, away from the active edge.
    int         hs_cnt = 0;
    int         fe_cnt = 0;
    int         ce_cnt = 0;
    int         fa_cnt = 0;
    logic [7:0] hs_data = 8'h00;

    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            hs_cnt  <= hs_cnt + 1;
            hs_data <= data_out;
        end
        if (frame_end)    fe_cnt <= fe_cnt + 1;
        if (code_err)     ce_cnt <= ce_cnt + 1;
        if (frame_active) fa_cnt <= fa_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half(input logic lvl, input int n);
        rx_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Manchester symbol; j moves the mid-bit edge by j cycles.
    task automatic sym(input logic b, input int j);
        if (b) begin
            half(1'b1, H + j);
            half(1'b0, H - j);
        end else begin
            half(1'b0, H + j);
            half(1'b1, H - j);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic par);
        for (int i = 0; i < 8; i++) sym(d[i], 0);
        sym(par, 0);
    endtask

    task automatic eof();
        half(1'b0, 2 * H + 24);
    endtask

    int hs0, fe0, ce0, fa0;

    task automatic snap();
        hs0 = hs_cnt;
        fe0 = fe_cnt;
        ce0 = ce_cnt;
        fa0 = fa_cnt;
    endtask

    int jit[9] = '{2, 2, -2, -2, 2, -2, -2, -2, 2};
    logic [7:0] a5 = 8'hA5;

    initial begin
        rst        = 1'b1;
        rx_in      = 1'b0;
        data_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        half(1'b0, 4);

        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_active", 32'(frame_active), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cerr", 32'(code_err), 32'd0);
        check("rst_fend", 32'(frame_end), 32'd0);

        // Clean 0xA5 frame, parity 1.
        snap();
        sym(1'b1, 0);
        check("t1_active", 32'(frame_active), 32'd1);
        send_byte(8'hA5, 1'b1);
        eof();
        check("t1_hs", 32'(hs_cnt - hs0), 32'd1);
        check("t1_data", 32'(hs_data), 32'hA5);
        check("t1_perr", 32'(parity_err), 32'd0);
        check("t1_fend", 32'(fe_cnt - fe0), 32'd1);
        check("t1_cerr", 32'(ce_cnt - ce0), 32'd0);
        check("t1_active_end", 32'(frame_active), 32'd0);

        // Same frame, bad parity bit.
        snap();
        sym(1'b1, 0);
        send_byte(8'hA5, 1'b0);
        eof();
        check("t2_hs", 32'(hs_cnt - hs0), 32'd1);
        check("t2_data", 32'(hs_data), 32'hA5);
        check("t2_perr", 32'(parity_err), 32'd1);
        check("t2_fend", 32'(fe_cnt - fe0), 32'd1);
        half(1'b0, 20);
        check("t2_perr_sticky", 32'(parity_err), 32'd1);

        // Two bytes with the consumer stalled: second is dropped.
        snap();
        data_ready = 1'b0;
        sym(1'b1, 0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFF, 1'b1);
        eof();
        check("t3_perr_clr", 32'(parity_err), 32'd0);
        check("t3_valid", 32'(data_valid), 32'd1);
        check("t3_data", 32'(data_out), 32'h3C);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_hs_none", 32'(hs_cnt - hs0), 32'd0);
        check("t3_fend", 32'(fe_cnt - fe0), 32'd1);
        data_ready = 1'b1;
        half(1'b0, 2);
        check("t3_hs", 32'(hs_cnt - hs0), 32'd1);
        check("t3_hs_data", 32'(hs_data), 32'h3C);
        check("t3_valid_clr", 32'(data_valid), 32'd0);

        // Truncated byte: 4 data bits then EOF.
        snap();
        sym(1'b1, 0);
        sym(1'b1, 0);
        sym(1'b0, 0);
        sym(1'b1, 0);
        sym(1'b1, 0);
        eof();
        check("t4_cerr", 32'(ce_cnt - ce0), 32'd1);
        check("t4_fend", 32'(fe_cnt - fe0), 32'd0);
        check("t4_hs", 32'(hs_cnt - hs0), 32'd0);
        check("t4_valid", 32'(data_valid), 32'd0);
        check("t4_active", 32'(frame_active), 32'd0);

        // Illegal (1,1) symbol mid-byte, then a clean 0x5A frame.
        snap();
        sym(1'b1, 0);
        sym(1'b1, 0);
        sym(1'b0, 0);
        sym(1'b0, 0);
        half(1'b1, 2 * H);
        half(1'b0, 40);
        check("t5_cerr", 32'(ce_cnt - ce0), 32'd1);
        check("t5_active", 32'(frame_active), 32'd0);
        snap();
        sym(1'b1, 0);
        send_byte(8'h5A, 1'b1);
        eof();
        check("t5_hs", 32'(hs_cnt - hs0), 32'd1);
        check("t5_data", 32'(hs_data), 32'h5A);
        check("t5_fend", 32'(fe_cnt - fe0), 32'd1);
        check("t5_cerr_clean", 32'(ce_cnt - ce0), 32'd0);
        check("t5_ovf_sticky", 32'(overflow), 32'd1);

        // 0xA5 with every mid-bit edge moved by +/-2 cycles.
        snap();
        sym(1'b1, 2);
        for (int i = 0; i < 8; i++) sym(a5[i], jit[i]);
        sym(1'b1, jit[8]);
        eof();
        check("t6_hs", 32'(hs_cnt - hs0), 32'd1);
        check("t6_data", 32'(hs_data), 32'hA5);
        check("t6_fend", 32'(fe_cnt - fe0), 32'd1);
        check("t6_cerr", 32'(ce_cnt - ce0), 32'd0);

        // Single-cycle idle pulse.
        snap();
        half(1'b1, 1);
        half(1'b0, 30);
`ifdef NFC_RX_GLITCH_FILTER_EN
        check("glitch_no_active", 32'(fa_cnt - fa0), 32'd0);
`else
        check("glitch_cerr", 32'(ce_cnt - ce0), 32'd0);
        check("glitch_fend", 32'(fe_cnt - fe0), 32'd0);
`endif
        check("glitch_active", 32'(frame_active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
